// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: redirect source kinds, valued by priority rank (higher value wins)
package pc_seq_pkg;
    typedef enum logic [2:0] {
        K_NONE = 3'd0,
        K_INC  = 3'd1,
        K_JMP  = 3'd2,
        K_BR   = 3'd3,
        K_ERET = 3'd4,
        K_INT  = 3'd5,
        K_EXC  = 3'd6
    } kind_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: request/redirect inputs and PC state outputs of the sequencer
interface pc_sequencer_if #(parameter int WIDTH = 32) ();
    logic             pc_write, inc, br_take, jmp_take;
    logic             exc_req, int_req, eret_req, ie_wr, ie_val;
    logic [WIDTH-1:0] br_pc, jmp_pc, victim_pc;
    logic [WIDTH-1:0] pc_out, epc_out;
    logic             ie_out, pend_out, addr_err;
    modport master (
        output pc_write, inc, br_take, jmp_take, exc_req, int_req, eret_req, ie_wr, ie_val,
        output br_pc, jmp_pc, victim_pc,
        input  pc_out, epc_out, ie_out, pend_out, addr_err
    );
    modport slave (
        input  pc_write, inc, br_take, jmp_take, exc_req, int_req, eret_req, ie_wr, ie_val,
        input  br_pc, jmp_pc, victim_pc,
        output pc_out, epc_out, ie_out, pend_out, addr_err
    );
endinterface

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: picks the current request and resolves it against the pending entry
module pc_redirect_arb
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               STEP    = 4,
    parameter logic [WIDTH-1:0] EXC_VEC = 32'h80000180,
    parameter logic [WIDTH-1:0] INT_VEC = 32'h80000200
) (
    input  logic             exc_req, int_req, eret_req, br_take, jmp_take, inc, ie,
    input  logic [WIDTH-1:0] pc, epc, br_pc, jmp_pc, victim_pc,
    input  kind_e            pend_kind,
    input  logic [WIDTH-1:0] pend_tgt, pend_victim,
    output kind_e            cur_kind,
    output logic [WIDTH-1:0] cur_tgt,
    output kind_e            win_kind,
    output logic [WIDTH-1:0] win_tgt, win_victim,
    output logic             misalign
);
    logic use_cur;
    always_comb begin
        cur_kind = exc_req ? K_EXC : (int_req && ie) ? K_INT : eret_req ? K_ERET :
                   br_take ? K_BR : jmp_take ? K_JMP : inc ? K_INC : K_NONE;
        cur_tgt = cur_kind == K_EXC ? EXC_VEC : cur_kind == K_INT ? INT_VEC :
                  cur_kind == K_ERET ? epc : cur_kind == K_BR ? br_pc :
                  cur_kind == K_JMP ? jmp_pc : pc + WIDTH'(STEP);
        // ties go to the live request so a re-raised trap saves the newer victim
        use_cur = cur_kind >= pend_kind;
        win_kind = use_cur ? cur_kind : pend_kind;
        win_tgt = use_cur ? cur_tgt : pend_tgt;
        win_victim = use_cur ? victim_pc : pend_victim;
        misalign = (win_kind inside {K_BR, K_JMP, K_ERET}) && ((win_tgt & WIDTH'(STEP - 1)) != '0);
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with stall buffering, traps, eret and alignment checks
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'hBFC00000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'h80000180,
    parameter logic [WIDTH-1:0] INT_VEC   = 32'h80000200
) (
    input logic          Clk,
    input logic          reset,
    pc_sequencer_if.slave bus
);
    logic [WIDTH-1:0] pc, epc, pend_tgt, pend_victim, cur_tgt, win_tgt, win_victim;
    logic             ie, addr_err, misalign, apply, trap;
    kind_e            pend_kind, cur_kind, win_kind;

    pc_redirect_arb #(.WIDTH(WIDTH), .STEP(STEP), .EXC_VEC(EXC_VEC), .INT_VEC(INT_VEC)) u_arb (
        .exc_req(bus.exc_req), .int_req(bus.int_req), .eret_req(bus.eret_req),
        .br_take(bus.br_take), .jmp_take(bus.jmp_take), .inc(bus.inc), .ie(ie),
        .pc(pc), .epc(epc), .br_pc(bus.br_pc), .jmp_pc(bus.jmp_pc), .victim_pc(bus.victim_pc),
        .pend_kind(pend_kind), .pend_tgt(pend_tgt), .pend_victim(pend_victim),
        .cur_kind(cur_kind), .cur_tgt(cur_tgt), .win_kind(win_kind), .win_tgt(win_tgt),
        .win_victim(win_victim), .misalign(misalign)
    );

    assign apply = bus.pc_write && win_kind != K_NONE;
    assign trap  = win_kind == K_EXC || win_kind == K_INT;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_VEC;
            epc         <= '0;
            ie          <= 1'b0;
            addr_err    <= 1'b0;
            pend_kind   <= K_NONE;
            pend_tgt    <= '0;
            pend_victim <= '0;
        end else begin
            addr_err <= 1'b0;
            if (bus.pc_write) pend_kind <= K_NONE;
            else if (cur_kind > K_INC && cur_kind >= pend_kind) begin
                pend_kind   <= cur_kind;
                pend_tgt    <= cur_tgt;
                pend_victim <= bus.victim_pc;
            end
            if (apply) pc <= misalign ? EXC_VEC : win_tgt;
            if (apply && misalign) begin
                epc      <= win_tgt;
                ie       <= 1'b0;
                addr_err <= 1'b1;
            end else if (apply && trap) begin
                epc <= win_victim;
                ie  <= 1'b0;
            end else if (apply && win_kind == K_ERET) ie <= 1'b1;
            else if (bus.ie_wr) ie <= bus.ie_val;
        end
    end

    assign bus.pc_out   = pc;
    assign bus.epc_out  = epc;
    assign bus.ie_out   = ie;
    assign bus.pend_out = pend_kind != K_NONE;
    assign bus.addr_err = addr_err;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with hand-computed expectations for pc_sequencer
module tb_pc_sequencer;
    logic Clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    pc_sequencer_if #(.WIDTH(32)) bus ();
    pc_sequencer dut (.Clk(Clk), .reset(reset), .bus(bus));

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.pc_write = 1'b1; bus.inc = 1'b0; bus.br_take = 1'b0; bus.jmp_take = 1'b0;
        bus.exc_req = 1'b0; bus.int_req = 1'b0; bus.eret_req = 1'b0;
        bus.ie_wr = 1'b0; bus.ie_val = 1'b0;
        bus.br_pc = '0; bus.jmp_pc = '0; bus.victim_pc = '0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        idle();
        step();
        chk("rst_pc", bus.pc_out, 32'hBFC00000);
        chk("rst_epc", bus.epc_out, 32'h0);
        chk("rst_ie", 32'(bus.ie_out), 32'h0);
        chk("rst_pend", 32'(bus.pend_out), 32'h0);
        chk("rst_aerr", 32'(bus.addr_err), 32'h0);
        reset = 1'b0;
        // sequential fetch
        bus.inc = 1'b1;
        step(); chk("inc1", bus.pc_out, 32'hBFC00004);
        step(); chk("inc2", bus.pc_out, 32'hBFC00008);
        step(); chk("inc3", bus.pc_out, 32'hBFC0000C);
        // stalled branch, lower-priority jump dropped
        idle(); bus.pc_write = 1'b0; bus.br_take = 1'b1; bus.br_pc = 32'h00400100;
        step(); chk("stall_pend", 32'(bus.pend_out), 32'h1); chk("stall_hold", bus.pc_out, 32'hBFC0000C);
        idle(); bus.pc_write = 1'b0; bus.jmp_take = 1'b1; bus.jmp_pc = 32'h00400200;
        step(); chk("stall_hold2", bus.pc_out, 32'hBFC0000C);
        idle();
        step(); chk("pend_apply", bus.pc_out, 32'h00400100); chk("pend_clr", 32'(bus.pend_out), 32'h0);
        // exception beats branch
        bus.jmp_take = 1'b1; bus.jmp_pc = 32'h00400010;
        step(); chk("jmp", bus.pc_out, 32'h00400010);
        idle(); bus.exc_req = 1'b1; bus.br_take = 1'b1; bus.br_pc = 32'h00400300; bus.victim_pc = 32'h00400010;
        step(); chk("exc_pc", bus.pc_out, 32'h80000180); chk("exc_epc", bus.epc_out, 32'h00400010);
        chk("exc_ie", 32'(bus.ie_out), 32'h0);
        // interrupt, eret, masked interrupt
        idle(); bus.ie_wr = 1'b1; bus.ie_val = 1'b1;
        step(); chk("iewr", 32'(bus.ie_out), 32'h1); chk("idle_hold", bus.pc_out, 32'h80000180);
        idle(); bus.int_req = 1'b1; bus.victim_pc = 32'h00400020;
        step(); chk("int_pc", bus.pc_out, 32'h80000200); chk("int_epc", bus.epc_out, 32'h00400020);
        chk("int_ie", 32'(bus.ie_out), 32'h0);
        idle(); bus.eret_req = 1'b1;
        step(); chk("eret_pc", bus.pc_out, 32'h00400020); chk("eret_ie", 32'(bus.ie_out), 32'h1);
        idle(); bus.ie_wr = 1'b1; bus.ie_val = 1'b0;
        step(); chk("iewr0", 32'(bus.ie_out), 32'h0);
        idle(); bus.int_req = 1'b1;
        step(); chk("int_masked", bus.pc_out, 32'h00400020);
        // exc and int together: exc only
        idle(); bus.ie_wr = 1'b1; bus.ie_val = 1'b1;
        step();
        idle(); bus.exc_req = 1'b1; bus.int_req = 1'b1; bus.victim_pc = 32'h00400024;
        step(); chk("excint_pc", bus.pc_out, 32'h80000180); chk("excint_epc", bus.epc_out, 32'h00400024);
        // misaligned jump
        idle(); bus.jmp_take = 1'b1; bus.jmp_pc = 32'h00400102;
        step(); chk("mis_pc", bus.pc_out, 32'h80000180); chk("mis_epc", bus.epc_out, 32'h00400102);
        chk("mis_aerr", 32'(bus.addr_err), 32'h1);
        idle();
        step(); chk("mis_aerr_clr", 32'(bus.addr_err), 32'h0); chk("mis_hold", bus.pc_out, 32'h80000180);
        // pending replaced by higher priority, lower dropped
        idle(); bus.pc_write = 1'b0; bus.jmp_take = 1'b1; bus.jmp_pc = 32'h00400400;
        step();
        idle(); bus.pc_write = 1'b0; bus.br_take = 1'b1; bus.br_pc = 32'h00400500;
        step();
        idle(); bus.pc_write = 1'b0; bus.jmp_take = 1'b1; bus.jmp_pc = 32'h00400600;
        step(); chk("repl_hold", bus.pc_out, 32'h80000180);
        idle();
        step(); chk("repl_apply", bus.pc_out, 32'h00400500);
        // wrap
        bus.jmp_take = 1'b1; bus.jmp_pc = 32'hFFFFFFFC;
        step(); chk("top_pc", bus.pc_out, 32'hFFFFFFFC);
        idle(); bus.inc = 1'b1;
        step(); chk("wrap", bus.pc_out, 32'h00000000);
        // async reset during stall with pending
        idle(); bus.pc_write = 1'b0; bus.br_take = 1'b1; bus.br_pc = 32'h00400700;
        step(); chk("pre_rst_pend", 32'(bus.pend_out), 32'h1);
        idle();
        #2 reset = 1'b1;
        #1 chk("arst_pend", 32'(bus.pend_out), 32'h0); chk("arst_pc", bus.pc_out, 32'hBFC00000);
        step();
        reset = 1'b0; bus.inc = 1'b1;
        chk("post_rst_pc", bus.pc_out, 32'hBFC00000);
        step(); chk("post_rst_inc", bus.pc_out, 32'hBFC00004);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
